// File: rtl/alu_cmd_sequencer.sv
// Command FIFO feeding a combinational 6-bit ALU, plus a registered, handshaked result slot.
// Optional res_zero output enabled by defining ALU_CMD_ZERO_FLAG_EN.
module alu_cmd_sequencer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [5:0]               cmd_a,
  input  logic [5:0]               cmd_b,
  input  logic [2:0]               cmd_fxn,
  output logic [5:0]               alu_a,
  output logic [5:0]               alu_b,
  output logic [2:0]               alu_fxn,
  input  logic [5:0]               alu_x,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [5:0]               res_x,
  output logic [2:0]               res_fxn,
  output logic [$clog2(DEPTH):0]   level
`ifdef ALU_CMD_ZERO_FLAG_EN
  ,
  output logic                     res_zero
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic {
    SLOT_EMPTY,
    SLOT_FULL
  } slot_t;

  slot_t          slot_q;
  slot_t          slot_d;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [14:0]    mem [DEPTH];
  logic [14:0]    head;
  logic           empty;
  logic           full;
  logic           push;
  logic           issue;

  always_comb begin
    empty     = (level == '0);
    full      = (level == LW'(DEPTH));
    // No pass-through at full: a same-cycle pop does not open cmd_ready.
    cmd_ready = !full;
    push      = cmd_valid && !full;
    issue     = !empty && ((slot_q == SLOT_EMPTY) || res_ready);
    head      = mem[rd_ptr];
    alu_a     = '0;
    alu_b     = '0;
    alu_fxn   = '0;
    if (!empty) begin
      alu_a   = head[14:9];
      alu_b   = head[8:3];
      alu_fxn = head[2:0];
    end
  end

  always_comb begin
    slot_d    = slot_q;
    res_valid = (slot_q == SLOT_FULL);
    case (slot_q)
      SLOT_EMPTY: if (issue) slot_d = SLOT_FULL;
      SLOT_FULL:  if (!issue && res_ready) slot_d = SLOT_EMPTY;
      default:    slot_d = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_a, cmd_b, cmd_fxn};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      slot_q  <= SLOT_EMPTY;
      res_x   <= '0;
      res_fxn <= '0;
`ifdef ALU_CMD_ZERO_FLAG_EN
      res_zero <= 1'b0;
`endif
    end else begin
      slot_q <= slot_d;
      if (push)  wr_ptr <= wr_ptr + AW'(1);
      if (issue) rd_ptr <= rd_ptr + AW'(1);
      case ({push, issue})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (issue) begin
        res_x   <= alu_x;
        res_fxn <= head[2:0];
`ifdef ALU_CMD_ZERO_FLAG_EN
        res_zero <= (alu_x == '0);
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer: vector table plus backpressure, wrap and reset sequences.
// A behavioural ALU closes the loop from alu_* back to alu_x.
module tb_alu_cmd_sequencer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [5:0]    cmd_a;
  logic [5:0]    cmd_b;
  logic [2:0]    cmd_fxn;
  logic [5:0]    alu_a;
  logic [5:0]    alu_b;
  logic [2:0]    alu_fxn;
  logic [5:0]    alu_x;
  logic          res_valid;
  logic          res_ready;
  logic [5:0]    res_x;
  logic [2:0]    res_fxn;
  logic [LW-1:0] level;
`ifdef ALU_CMD_ZERO_FLAG_EN
  logic          res_zero;
`endif

  alu_cmd_sequencer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_fxn   (cmd_fxn),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_fxn   (alu_fxn),
    .alu_x     (alu_x),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_x     (res_x),
    .res_fxn   (res_fxn),
    .level     (level)
`ifdef ALU_CMD_ZERO_FLAG_EN
    ,
    .res_zero  (res_zero)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] alu_model(input logic [5:0] a, input logic [5:0] b,
                                           input logic [2:0] f);
    case (f)
      3'b000:  return a;
      3'b001:  return b;
      3'b010:  return ~a;
      3'b011:  return a & b;
      3'b100:  return a | b;
      3'b101:  return ~(a ^ b);
      3'b110:  return a + b;
      default: return a - b;
    endcase
  endfunction

  assign alu_x = alu_model(alu_a, alu_b, alu_fxn);

  typedef struct packed {
    logic [5:0] x;
    logic [2:0] f;
  } res_t;

  typedef struct {
    logic       v;
    logic [5:0] a;
    logic [5:0] b;
    logic [2:0] f;
    logic       rr;
    logic       e_rv;
    logic [5:0] e_x;
    logic [2:0] e_f;
    int         e_lvl;
    logic [2:0] e_afxn;
  } vec_t;

  int   n_cmp = 0;
  int   n_err = 0;
  int   n_got = 0;
  res_t exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drives one cycle from a negedge; scores any result consumed at the coming edge.
  task automatic cycle(input logic v, input logic [5:0] a, input logic [5:0] b,
                       input logic [2:0] f, input logic rr);
    res_t e;
    res_t n;
    cmd_valid = v;
    cmd_a     = a;
    cmd_b     = b;
    cmd_fxn   = f;
    res_ready = rr;
    if (res_valid && rr) begin
      if (exp_q.size() == 0) begin
        chk("sb_extra_result", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_res_x", int'(res_x), int'(e.x));
        chk("sb_res_fxn", int'(res_fxn), int'(e.f));
        n_got++;
      end
    end
    if (v && cmd_ready) begin
      n.x = alu_model(a, b, f);
      n.f = f;
      exp_q.push_back(n);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs [6];
    logic [5:0] x0;
    int         accepted;
    int         got0;

    vecs[0] = '{1'b1, 6'b010010, 6'b010011, 3'b111, 1'b1, 1'b0, 6'b000000, 3'b000, 1, 3'b111};
    vecs[1] = '{1'b1, 6'b010010, 6'b010011, 3'b110, 1'b1, 1'b1, 6'b111111, 3'b111, 1, 3'b110};
    vecs[2] = '{1'b1, 6'b010010, 6'b010011, 3'b101, 1'b1, 1'b1, 6'b100101, 3'b110, 1, 3'b101};
    vecs[3] = '{1'b1, 6'b010010, 6'b010011, 3'b000, 1'b1, 1'b1, 6'b111110, 3'b101, 1, 3'b000};
    vecs[4] = '{1'b0, 6'b000000, 6'b000000, 3'b000, 1'b1, 1'b1, 6'b010010, 3'b000, 0, 3'b000};
    vecs[5] = '{1'b0, 6'b000000, 6'b000000, 3'b000, 1'b1, 1'b0, 6'b010010, 3'b000, 0, 3'b000};

    rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_fxn = '0; res_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_x", int'(res_x), 0);
    chk("rst_res_fxn", int'(res_fxn), 0);
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_level", int'(level), 0);
    chk("rst_alu_a", int'(alu_a), 0);
    chk("rst_alu_b", int'(alu_b), 0);
    chk("rst_alu_fxn", int'(alu_fxn), 0);

    // Single command then back-to-back commands, one result per cycle.
    for (int i = 0; i < 6; i++) begin
      cmd_valid = vecs[i].v; cmd_a = vecs[i].a; cmd_b = vecs[i].b;
      cmd_fxn = vecs[i].f; res_ready = vecs[i].rr;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_res_valid", i), int'(res_valid), int'(vecs[i].e_rv));
      chk($sformatf("vec%0d_res_x", i), int'(res_x), int'(vecs[i].e_x));
      chk($sformatf("vec%0d_res_fxn", i), int'(res_fxn), int'(vecs[i].e_f));
      chk($sformatf("vec%0d_level", i), int'(level), vecs[i].e_lvl);
      chk($sformatf("vec%0d_alu_fxn", i), int'(alu_fxn), int'(vecs[i].e_afxn));
    end

    // Backpressure: DEPTH+1 pushes with res_ready low.
    x0 = alu_model(6'd3, 6'd9, 3'b110);
    for (int i = 0; i <= int'(DEPTH); i++) begin
      cycle(1'b1, 6'(3 + i), 6'(9 + 2 * i), 3'(6 + i), 1'b0);
      chk($sformatf("bp%0d_level", i), int'(level), (i == 0) ? 1 : i);
      chk($sformatf("bp%0d_cmd_ready", i), int'(cmd_ready), (i < int'(DEPTH)) ? 1 : 0);
      if (i >= 1) begin
        chk($sformatf("bp%0d_res_valid", i), int'(res_valid), 1);
        chk($sformatf("bp%0d_res_x_hold", i), int'(res_x), int'(x0));
      end
    end
    cycle(1'b1, 6'd63, 6'd63, 3'b000, 1'b0);
    chk("bp_full_level", int'(level), int'(DEPTH));
    chk("bp_full_res_x_hold", int'(res_x), int'(x0));
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) cycle(1'b0, '0, '0, '0, 1'b1);
    chk("bp_drain_empty", exp_q.size(), 0);
    chk("bp_drain_level", int'(level), 0);
    chk("bp_drain_res_valid", int'(res_valid), 0);

    // Wrap-around with res_ready toggling every cycle.
    accepted = 0;
    got0 = n_got;
    for (int c = 0; c < 400 && (accepted < 3 * int'(DEPTH) || exp_q.size() > 0); c++) begin
      logic v;
      v = (accepted < 3 * int'(DEPTH));
      if (v && cmd_ready) begin
        cycle(1'b1, 6'(accepted * 7 + 3), 6'(accepted * 5 + 1), 3'(accepted), 1'(c));
        accepted++;
      end else begin
        cycle(v, 6'(accepted * 7 + 3), 6'(accepted * 5 + 1), 3'(accepted), 1'(c));
      end
    end
    chk("wrap_accepted", accepted, 3 * int'(DEPTH));
    chk("wrap_drained", exp_q.size(), 0);
    chk("wrap_result_count", n_got - got0, 3 * int'(DEPTH));
    cycle(1'b0, '0, '0, '0, 1'b1);

    // Reset with level=3 and slot full.
    for (int i = 0; i < 4; i++) cycle(1'b1, 6'(10 + i), 6'(20 + i), 3'(i + 1), 1'b0);
    chk("pre_rst_level", int'(level), 3);
    chk("pre_rst_res_valid", int'(res_valid), 1);
    rst = 1'b1; cmd_valid = 1'b1; res_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; cmd_valid = 1'b0;
    exp_q.delete();
    chk("mid_rst_level", int'(level), 0);
    chk("mid_rst_res_valid", int'(res_valid), 0);
    chk("mid_rst_cmd_ready", int'(cmd_ready), 1);
    chk("mid_rst_alu_fxn", int'(alu_fxn), 0);
    chk("mid_rst_res_x", int'(res_x), 0);

`ifdef ALU_CMD_ZERO_FLAG_EN
    cycle(1'b1, 6'b010010, 6'b010010, 3'b111, 1'b1);
    chk("zf_init_res_zero", int'(res_zero), 0);
    cycle(1'b1, 6'b010010, 6'b010010, 3'b110, 1'b1);
    chk("zf_sub_res_x", int'(res_x), 0);
    chk("zf_sub_res_zero", int'(res_zero), 1);
    cycle(1'b0, '0, '0, '0, 1'b1);
    chk("zf_add_res_x", int'(res_x), 36);
    chk("zf_add_res_zero", int'(res_zero), 0);
    cycle(1'b0, '0, '0, '0, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
